shift_add_mult: RTL
===================

# shift_add_mult

Iterative shift-and-add unsigned multiplier that produces a 2*WL-bit product from two WL-bit operands over WL clock cycles. It is the stage directly upstream of the product register `p_reg`: its `p` output and `done` strobe feed that register's data input and capture enable. Operands are captured on a start handshake, and the result is held stable until the next operation completes.

## Interface
- `WL`, default 4, operand width in bits; valid range 2..32.
- `clk`  input  1  single system clock; all state updates on rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `start`  input  1  request to begin a multiply; sampled on rising edge.
- `a`  input  WL  multiplicand, unsigned; captured at accepted start.
- `b`  input  WL  multiplier, unsigned; captured at accepted start.
- `busy`  output  1  high while an operation is in progress.
- `done`  output  1  one-cycle strobe: `p` has just been updated.
- `p`  output  2*WL  product, unsigned; held between completions.

## Operation
- States: IDLE, CALC. Registered `done` and `p` are separate from the state register.
- Internal registers: `a_reg` (WL), `acc` (2*WL, upper half accumulates, lower half holds remaining multiplier bits), `cnt` (ceil(log2(WL+1)) bits).
- IDLE:
  - `start`=1 at an edge: `a_reg`<=`a`, `acc`<={WL'b0, `b`}, `cnt`<=0, go to CALC.
  - `start`=0: stay in IDLE.
- CALC, per edge, one multiplier bit, LSB first:
  - sum = `acc[0]` ? (`acc[2WL-1:WL]` + `a_reg`) : `acc[2WL-1:WL]`, computed WL+1 bits wide.
  - `acc` <= {sum, `acc[WL-1:1]`}, i.e. the (WL+1)-bit sum concatenated with the shifted low half, logical right shift by one with the carry entering the MSB.
  - `cnt`<=`cnt`+1.
  - When `cnt`==WL-1 (the last iteration), also `p`<=next `acc` value, `done`<=1, and go to IDLE.
- `done` is cleared at every edge where it is not being set.
- `start` while in CALC is ignored; no queuing, and the operands in flight are unaffected.
- Arithmetic: exact unsigned product. No overflow is possible, since max (2^WL-1)^2 < 2^(2WL).
- `a`/`b` may change freely after the accepting edge.
- `busy` = (state==CALC), combinational decode of the state register.

## Timing
- Reset (async assert, any time): state IDLE, `p`=0, `done`=0, `busy`=0, `acc`=0, `a_reg`=0, `cnt`=0. Outputs change without waiting for a clock edge.
- Reset mid-CALC aborts the operation. No `done`, and `p` reads 0.
- After reset deassertion, the first rising edge with `start`=1 is accepted.
- Start accepted at edge k:
  - `busy` high from after edge k until after edge k+WL.
  - `p` valid and `done` high during the cycle following edge k+WL.
  - Latency from start edge to `done` is WL+1 edges.
- Back-to-back: `start`=1 during the cycle `done` is high is accepted at that edge (state is IDLE). Then:
  - `done` falls.
  - `p` keeps the previous result until the new completion.
- Throughput: one result per WL+1 cycles maximum.
- `p` changes only at completion edges or on reset, so downstream `p_reg` may capture on `done` or on every edge.

## Test plan
- Reset: assert `rst` asynchronously between edges -> `p`=0, `done`=0, `busy`=0 immediately. Release, with `start` held low for 5 cycles -> outputs stay unchanged.
- Basic, WL=4: `a`=5, `b`=3, `start` pulse at edge k -> `busy`=1 for 4 cycles; `done`=1 for exactly one cycle after edge k+4 with `p`=0x0F. `p` still reads 0x0F 10 cycles later.
- Corners, WL=4:
  - `a`=0xF, `b`=0xF -> `p`=0xE1, exercising the carry into the MSB.
  - `a`=0, `b`=0xA -> `p`=0x00.
  - `a`=0xA, `b`=0x1 -> `p`=0x0A.
  - `a`=0x8, `b`=0x8 -> `p`=0x40.
- Start while busy: `a`=3, `b`=4 accepted. At edge k+2, pulse `start` with `a`=7, `b`=7 -> ignored; single `done` with `p`=0x0C, and no second `done`.
- Back-to-back: second `start` (`a`=6, `b`=7) held high during the first `done` cycle (first op `a`=2, `b`=3) -> `p`=0x06 then 0x2A. `done` pulses are 5 cycles apart, and `p` stays 0x06 in between.
- Reset mid-operation: `a`=0xF, `b`=0xF started, `rst` pulsed at cycle k+2 -> no `done`, `p`=0. A fresh `start` with `a`=2, `b`=2 -> `p`=0x04 after 5 edges.

Source files
------------

// File: rtl/shift_add_mult_if.sv
// Start/operand/result bundle between the shift-and-add multiplier and its requester.
interface shift_add_mult_if #(
  parameter int unsigned WL = 4
);

  logic              start;
  logic [WL-1:0]     a;
  logic [WL-1:0]     b;
  logic              busy;
  logic              done;
  logic [2*WL-1:0]   p;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  p
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output p
  );

endinterface

// File: rtl/shift_add_mult.sv
// Iterative unsigned shift-and-add multiplier: one multiplier bit per cycle, LSB first,
// 2*WL-bit product held in a register that changes only on completion or reset.
module shift_add_mult #(
  parameter int unsigned WL = 4
) (
  input  logic              clk,
  input  logic              rst,
  shift_add_mult_if.slave   bus
);

  localparam int unsigned PW = 2 * WL;
  localparam int unsigned CW = $clog2(WL + 1);
  localparam int unsigned SW = WL + 1;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [WL-1:0]   a_reg_q, a_reg_d;
  logic [PW-1:0]   acc_q,   acc_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [PW-1:0]   p_q,     p_d;
  logic            done_q,  done_d;

  logic [SW-1:0]   sum;
  logic [PW-1:0]   acc_step;

  // Conditional add of the multiplicand into the upper half; carry lands in the MSB after the shift.
  always_comb begin
    sum      = SW'(acc_q[PW-1:WL]);
    if (acc_q[0]) begin
      sum = SW'(acc_q[PW-1:WL]) + SW'(a_reg_q);
    end
    acc_step = {sum, acc_q[WL-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_reg_d = a_reg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_reg_d = bus.a;
          acc_d   = {WL'(0), bus.b};
          cnt_d   = CW'(0);
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WL - 1)) begin
          p_d     = acc_step;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_reg_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_reg_q <= a_reg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == CALC);
  assign bus.done = done_q;
  assign bus.p    = p_q;

endmodule
